// File: rtl/btn_debounce_pkg.sv
// Shared types and constants for the push-button debounce front end.
package btn_debounce_pkg;

    // Per-button debounce state.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ARM  = 2'b01,
        ST_HELD = 2'b10,
        ST_REL  = 2'b11
    } db_state_t;

    // Button roles as seen by the downstream operand/opcode loader.
    localparam int BTN_DATA_A  = 0;
    localparam int BTN_DATA_B  = 1;
    localparam int BTN_OP_CODE = 2;

endpackage

// File: rtl/btn_debounce_fsm.sv
// One button's debounce FSM: a level change is accepted only after
// DB_CYCLES consecutive stable synced cycles. o_accept pulses on the
// cycle the FSM commits to HELD (one per physical press).
module btn_debounce_fsm
    import btn_debounce_pkg::*;
#(
    parameter int NB_DB_CNT = 20,
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic i_rst,
    input  logic i_sync,
    output logic o_accept,
    output logic o_held
);

    localparam logic [NB_DB_CNT-1:0] CNT_LAST = NB_DB_CNT'(DB_CYCLES - 1);
    localparam logic [NB_DB_CNT-1:0] CNT_ONE  = NB_DB_CNT'(1);

    db_state_t            state, state_nxt;
    logic [NB_DB_CNT-1:0] cnt, cnt_nxt;

    // State and stability counter registers.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state; the counter is cleared on every transition so it never wraps.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        o_accept  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_sync) begin
                    state_nxt = ST_ARM;
                    cnt_nxt   = '0;
                end
            end
            ST_ARM: begin
                if (!i_sync) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_HELD;
                    cnt_nxt   = '0;
                    o_accept  = 1'b1;
                end else begin
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end
            ST_HELD: begin
                if (!i_sync) begin
                    state_nxt = ST_REL;
                    cnt_nxt   = '0;
                end
            end
            ST_REL: begin
                // Bouncing back high during release returns to HELD silently.
                if (i_sync) begin
                    state_nxt = ST_HELD;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign o_held = (state == ST_HELD) || (state == ST_REL);

endmodule

// File: rtl/btn_debounce_ctrl.sv
// Button/switch front end: synchronizes raw inputs, debounces each button,
// and serializes accepted presses into single-cycle o_valid pulses carrying
// a one-hot button id and the switch value sampled with that pulse.
module btn_debounce_ctrl
    import btn_debounce_pkg::*;
#(
    parameter int NB_BTN    = 3,
    parameter int NB_SW     = 8,
    parameter int NB_DB_CNT = 20,
    parameter int DB_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic [NB_BTN-1:0] i_btn_raw,
    input  logic [NB_SW-1:0]  i_sw_raw,
    output logic              o_valid,
    output logic [NB_BTN-1:0] o_btn,
    output logic [NB_SW-1:0]  o_sw_data,
    output logic [NB_BTN-1:0] o_btn_held
);

    logic [NB_BTN-1:0] btn_meta, btn_sync;
    logic [NB_SW-1:0]  sw_meta, sw_sync;
    logic [NB_BTN-1:0] accept;
    logic [NB_BTN-1:0] pending;
    logic [NB_BTN-1:0] grant;

    // Two-flop synchronizers for all raw inputs.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            btn_meta <= '0;
            btn_sync <= '0;
            sw_meta  <= '0;
            sw_sync  <= '0;
        end else begin
            btn_meta <= i_btn_raw;
            btn_sync <= btn_meta;
            sw_meta  <= i_sw_raw;
            sw_sync  <= sw_meta;
        end
    end

    generate
        for (genvar g = 0; g < NB_BTN; g++) begin : g_btn
            btn_debounce_fsm #(
                .NB_DB_CNT (NB_DB_CNT),
                .DB_CYCLES (DB_CYCLES)
            ) u_fsm (
                .clk      (clk),
                .i_rst    (i_rst),
                .i_sync   (btn_sync[g]),
                .o_accept (accept[g]),
                .o_held   (o_btn_held[g])
            );
        end
    endgenerate

    // Fixed priority: lowest-index pending press is served first.
    always_comb begin
        grant = '0;
        for (int i = NB_BTN - 1; i >= 0; i--) begin
            if (pending[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end

    // Pending presses; a new acceptance wins over a same-cycle grant clear.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~grant) | accept;
        end
    end

    // Output register: one pulse per granted press, switch data held between pulses.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid   <= 1'b0;
            o_btn     <= '0;
            o_sw_data <= '0;
        end else begin
            o_valid <= |pending;
            o_btn   <= grant;
            if (|pending) begin
                o_sw_data <= sw_sync;
            end
        end
    end

endmodule
